// File: rtl/poly_arith_pkg.sv
// Shared polynomial-arithmetic types and constants for the Kyber-style
// coefficient datapath (q = 3329, 12-bit coefficients).
package poly_arith_pkg;

    localparam int COEFF_W = 12;
    typedef logic [COEFF_W-1:0] coeff_t;

    localparam coeff_t Q = 12'd3329;

    localparam int MOD_MUL_LAT = 3;

    // Wide enough for up to 8 requesters; users slice down to their ID_W.
    localparam int TAG_ID_W = 3;

    typedef struct packed {
        logic                vld;
        logic [TAG_ID_W-1:0] id;
    } mul_tag_t;

    localparam logic [13:0] Q1_14 = 14'd3329;
    localparam logic [13:0] Q2_14 = 14'd6658;

    function automatic coeff_t reduce_3q(input logic [13:0] r);
        logic [13:0] v;
        v = r;
        if (v >= Q2_14) begin
            v = v - Q2_14;
        end else if (v >= Q1_14) begin
            v = v - Q1_14;
        end
        return COEFF_W'(v);
    endfunction

endpackage

// File: rtl/mod_mul.sv
// Pipelined modular multiplier: (a*b) mod q with Barrett reduction,
// fixed MOD_MUL_LAT-cycle latency, never stalls.
module mod_mul
    import poly_arith_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   valid_i,
    input  coeff_t op1_i,
    input  coeff_t op2_i,
    output coeff_t result_o,
    output logic   valid_o
);

    // floor(2^24 / q); quotient estimate is short by at most 2.
    localparam logic [12:0] BARRETT_M = 13'd5039;

    logic [23:0]            prod_q;
    logic [13:0]            red_q;
    coeff_t                 res_q;
    logic [MOD_MUL_LAT-1:0] vld_q;

    logic [12:0] quot_d;
    logic [13:0] red_d;

    always_comb begin
        quot_d = 13'((37'(prod_q) * 37'(BARRETT_M)) >> 24);
        red_d  = 14'(prod_q - 24'(quot_d) * 24'(Q));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q <= '0;
            red_q  <= '0;
            res_q  <= '0;
            vld_q  <= '0;
        end else begin
            prod_q <= 24'(op1_i) * 24'(op2_i);
            red_q  <= red_d;
            res_q  <= reduce_3q(red_q);
            vld_q  <= {vld_q[MOD_MUL_LAT-2:0], valid_i};
        end
    end

    assign result_o = res_q;
    assign valid_o  = vld_q[MOD_MUL_LAT-1];

endmodule

// File: rtl/mod_mul_res_fifo.sv
// First-word-fall-through result FIFO holding {coeff, requester id}.
// Output data reads as zero while empty.
module mod_mul_res_fifo
    import poly_arith_pkg::*;
#(
    parameter  int DEPTH = 8,
    parameter  int ID_W  = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  coeff_t           wr_data_i,
    input  logic [ID_W-1:0]  wr_id_i,
    input  logic             rd_en_i,
    output coeff_t           rd_data_o,
    output logic [ID_W-1:0]  rd_id_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int ENT_W = COEFF_W + ID_W;

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_wr;
    logic             do_rd;

    always_comb begin
        empty_o  = (cnt_q == '0);
        full_o   = (cnt_q == CNT_W'(DEPTH));
        do_wr    = wr_en_i & ~full_o;
        do_rd    = rd_en_i & ~empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (do_rd) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        cnt_d = cnt_q + CNT_W'(do_wr) - CNT_W'(do_rd);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_wr) begin
                mem_q[wr_ptr_q] <= {wr_data_i, wr_id_i};
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        {rd_data_o, rd_id_o} = empty_o ? '0 : mem_q[rd_ptr_q];
        count_o = cnt_q;
    end

    assert property (@(posedge clk) disable iff (!rst_n) !(wr_en_i && full_o));

endmodule

// File: rtl/mod_mul_arbiter.sv
// Round-robin sharing of one pipelined mod_mul among N_REQ requesters;
// results return in issue order through a credit-protected FIFO.
module mod_mul_arbiter
    import poly_arith_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int RES_DEPTH = 8,
    parameter int ID_W      = $clog2(N_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid_i,
    output logic [N_REQ-1:0]         req_ready_o,
    input  logic [N_REQ*COEFF_W-1:0] req_op1_i,
    input  logic [N_REQ*COEFF_W-1:0] req_op2_i,
    output logic                     res_valid_o,
    input  logic                     res_ready_i,
    output coeff_t                   res_data_o,
    output logic [ID_W-1:0]          res_id_o,
    output logic                     busy_o
);

    localparam int CNT_W = $clog2(RES_DEPTH + 1);

    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mul_tag_t         tag_q [MOD_MUL_LAT];
    mul_tag_t         tag_last;

    logic [ID_W:0]    cand;
    logic [ID_W-1:0]  cand_id;
    logic [ID_W-1:0]  gnt_idx;
    logic             gnt_found;
    logic             issue_ok;
    logic             issue;
    logic             pop;

    coeff_t           mul_op1;
    coeff_t           mul_op2;
    coeff_t           mul_res;
    logic             mul_vld;

    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_cnt;

    // Credit covers in-flight products too, so the FIFO can never overflow.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        cand_id   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (ID_W + 1)'(ptr_q) + (ID_W + 1)'(k);
            if (cand >= (ID_W + 1)'(N_REQ)) begin
                cand = cand - (ID_W + 1)'(N_REQ);
            end
            cand_id = ID_W'(cand);
            if (!gnt_found && req_valid_i[cand_id]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand_id;
            end
        end
        issue_ok = (cnt_q < CNT_W'(RES_DEPTH));
        issue    = gnt_found & issue_ok & rst_n;
    end

    always_comb begin
        req_ready_o = '0;
        if (issue) begin
            req_ready_o[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        mul_op1 = req_op1_i[COEFF_W*gnt_idx +: COEFF_W];
        mul_op2 = req_op2_i[COEFF_W*gnt_idx +: COEFF_W];
        pop     = ~fifo_empty & res_ready_i;
        ptr_d   = ptr_q;
        if (issue) begin
            ptr_d = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        end
        cnt_d = cnt_q + CNT_W'(issue) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
            for (int s = 0; s < MOD_MUL_LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            tag_q[0].vld <= issue;
            tag_q[0].id  <= TAG_ID_W'(gnt_idx);
            for (int s = 1; s < MOD_MUL_LAT; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    assign tag_last = tag_q[MOD_MUL_LAT-1];

    mod_mul u_mod_mul (
        .clk      (clk),
        .rst      (~rst_n),
        .valid_i  (issue),
        .op1_i    (mul_op1),
        .op2_i    (mul_op2),
        .result_o (mul_res),
        .valid_o  (mul_vld)
    );

    mod_mul_res_fifo #(
        .DEPTH (RES_DEPTH),
        .ID_W  (ID_W)
    ) u_res_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (tag_last.vld),
        .wr_data_i (mul_res),
        .wr_id_i   (tag_last.id[ID_W-1:0]),
        .rd_en_i   (pop),
        .rd_data_o (res_data_o),
        .rd_id_o   (res_id_o),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_cnt)
    );

    assign res_valid_o = ~fifo_empty;
    assign busy_o      = (cnt_q != '0);

    assert property (@(posedge clk) disable iff (!rst_n) mul_vld == tag_last.vld);
    assert property (@(posedge clk) disable iff (!rst_n) !(tag_last.vld && fifo_full));
    assert property (@(posedge clk) disable iff (!rst_n)
        !tag_last.vld || (tag_last.id < TAG_ID_W'(N_REQ)));
    assert property (@(posedge clk) disable iff (!rst_n) fifo_cnt <= cnt_q);

endmodule
